// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream interface: timing from the sync generator in, registered colour and sync out.
interface vga_pattern_gen_if #(
    parameter int COLOR_BITS = 2
);
    logic [9:0]            pix_x;
    logic [9:0]            pix_y;
    logic                  video_active;
    logic                  hsync_in;
    logic                  vsync_in;
    logic [COLOR_BITS-1:0] r_out;
    logic [COLOR_BITS-1:0] g_out;
    logic [COLOR_BITS-1:0] b_out;
    logic                  hsync_out;
    logic                  vsync_out;

    modport master (
        output pix_x, pix_y, video_active, hsync_in, vsync_in,
        input  r_out, g_out, b_out, hsync_out, vsync_out
    );

    modport slave (
        input  pix_x, pix_y, video_active, hsync_in, vsync_in,
        output r_out, g_out, b_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Four-mode VGA test pattern generator (checker, bars, gradient, bouncing sprite).
// Optional macro PATGEN_SCROLL_EN scrolls checker and bars left one pixel per frame.
module vga_pattern_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int TILE_LOG2   = 5,
    parameter int SPRITE_SIZE = 64,
    parameter int COLOR_BITS  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_pattern_gen_if.slave  vif,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    input  logic              pause,
    output logic              frame_tick
);

    typedef enum logic {DIR_FWD = 1'b0, DIR_REV = 1'b1} dir_t;

    typedef struct packed {
        logic [9:0] pos;
        dir_t       dir;
        logic       bounce;
    } axis_t;

    localparam logic [9:0]  X_LIMIT = 10'(H_ACTIVE - SPRITE_SIZE);
    localparam logic [9:0]  Y_LIMIT = 10'(V_ACTIVE - SPRITE_SIZE);
    localparam logic [9:0]  V_END   = 10'(V_ACTIVE);
    localparam int          BAR_W   = H_ACTIVE / 8;
    localparam logic [10:0] SPR_W   = 11'(SPRITE_SIZE);

    // One frame of motion for one axis; clamps to the wall and reports a bounce.
    function automatic axis_t axis_step(input logic [9:0] pos, input dir_t dir,
                                        input logic [2:0] step, input logic [9:0] limit);
        axis_t      res;
        logic [10:0] sum;
        sum        = {1'b0, pos} + {8'd0, step};
        res.pos    = pos;
        res.dir    = dir;
        res.bounce = 1'b0;
        case (dir)
            DIR_FWD: begin
                if (sum >= {1'b0, limit}) begin
                    res.pos    = limit;
                    res.dir    = DIR_REV;
                    res.bounce = 1'b1;
                end else begin
                    res.pos = sum[9:0];
                end
            end
            DIR_REV: begin
                if (pos <= {7'd0, step}) begin
                    res.pos    = 10'd0;
                    res.dir    = DIR_FWD;
                    res.bounce = 1'b1;
                end else begin
                    res.pos = pos - {7'd0, step};
                end
            end
            default: res.bounce = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [COLOR_BITS-1:0] expand(input logic b);
        return {COLOR_BITS{b}};
    endfunction

    logic [9:0]            sprite_x_r, sprite_y_r;
    dir_t                  dir_x_r, dir_y_r;
    logic [2:0]            color_idx_r;
    logic [7:0]            frame_cnt_r;
    logic [1:0]            active_mode_r;

    logic [9:0]            sprite_x_nx_s, sprite_y_nx_s;
    dir_t                  dir_x_nx_s, dir_y_nx_s;
    logic [2:0]            color_idx_nx_s;
    logic [7:0]            frame_cnt_nx_s;
    logic [1:0]            active_mode_nx_s;

    logic                  tick_s, move_s;
    logic [2:0]            step_s;
    axis_t                 axis_x_s, axis_y_s;
    logic [9:0]            x_eff_s;
    logic [7:0]            grad_sum_s;
    logic                  in_sprite_s;
    logic [2:0]            bar_idx_s, sprite_pal_s, pal_idx_s;
    logic [COLOR_BITS-1:0] r_s, g_s, b_s;

    assign tick_s     = (vif.pix_x == 10'd0) && (vif.pix_y == V_END);
    assign move_s     = tick_s && !pause;
    assign step_s     = {1'b0, speed} + 3'd1;
    assign grad_sum_s = vif.pix_x[7:0] + vif.pix_y[7:0];

`ifdef PATGEN_SCROLL_EN
    assign x_eff_s = vif.pix_x + {2'b00, frame_cnt_r};
`else
    assign x_eff_s = vif.pix_x;
`endif

    assign in_sprite_s = ({1'b0, vif.pix_x} >= {1'b0, sprite_x_r}) &&
                         ({1'b0, vif.pix_x} <  ({1'b0, sprite_x_r} + SPR_W)) &&
                         ({1'b0, vif.pix_y} >= {1'b0, sprite_y_r}) &&
                         ({1'b0, vif.pix_y} <  ({1'b0, sprite_y_r} + SPR_W));

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sprite_x_r    <= 10'd0;
            sprite_y_r    <= 10'd0;
            dir_x_r       <= DIR_FWD;
            dir_y_r       <= DIR_FWD;
            color_idx_r   <= 3'd0;
            frame_cnt_r   <= 8'd0;
            active_mode_r <= 2'd0;
            frame_tick    <= 1'b0;
            vif.r_out     <= '0;
            vif.g_out     <= '0;
            vif.b_out     <= '0;
            vif.hsync_out <= 1'b0;
            vif.vsync_out <= 1'b0;
        end else begin
            sprite_x_r    <= sprite_x_nx_s;
            sprite_y_r    <= sprite_y_nx_s;
            dir_x_r       <= dir_x_nx_s;
            dir_y_r       <= dir_y_nx_s;
            color_idx_r   <= color_idx_nx_s;
            frame_cnt_r   <= frame_cnt_nx_s;
            active_mode_r <= active_mode_nx_s;
            frame_tick    <= tick_s;
            vif.r_out     <= r_s;
            vif.g_out     <= g_s;
            vif.b_out     <= b_s;
            vif.hsync_out <= vif.hsync_in;
            vif.vsync_out <= vif.vsync_in;
        end
    end

    // Next-state: per-axis bounce FSM, colour step on any bounce, mode latch at frame end.
    always_comb begin
        axis_x_s = axis_step(sprite_x_r, dir_x_r, step_s, X_LIMIT);
        axis_y_s = axis_step(sprite_y_r, dir_y_r, step_s, Y_LIMIT);
        if (move_s) begin
            sprite_x_nx_s  = axis_x_s.pos;
            sprite_y_nx_s  = axis_y_s.pos;
            dir_x_nx_s     = axis_x_s.dir;
            dir_y_nx_s     = axis_y_s.dir;
            // A corner bounce still advances the colour by one.
            color_idx_nx_s = color_idx_r + {2'b00, axis_x_s.bounce | axis_y_s.bounce};
            frame_cnt_nx_s = frame_cnt_r + 8'd1;
        end else begin
            sprite_x_nx_s  = sprite_x_r;
            sprite_y_nx_s  = sprite_y_r;
            dir_x_nx_s     = dir_x_r;
            dir_y_nx_s     = dir_y_r;
            color_idx_nx_s = color_idx_r;
            frame_cnt_nx_s = frame_cnt_r;
        end
        if (tick_s) begin
            active_mode_nx_s = mode;
        end else begin
            active_mode_nx_s = active_mode_r;
        end
    end

    // Pixel colour for the current position, blanked outside the active area.
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            bar_idx_s = bar_idx_s + {2'b00, (x_eff_s >= 10'(k * BAR_W))};
        end
        sprite_pal_s = (color_idx_r == 3'd0) ? 3'd1 : color_idx_r;
        case (active_mode_r)
            2'd0:    pal_idx_s = {3{x_eff_s[TILE_LOG2] ^ vif.pix_y[TILE_LOG2]}};
            2'd1:    pal_idx_s = 3'd7 - bar_idx_s;
            2'd3:    pal_idx_s = in_sprite_s ? sprite_pal_s : 3'd0;
            default: pal_idx_s = 3'd0;
        endcase
        if (!vif.video_active) begin
            r_s = '0;
            g_s = '0;
            b_s = '0;
        end else if (active_mode_r == 2'd2) begin
            r_s = vif.pix_x[7 -: COLOR_BITS];
            g_s = vif.pix_y[7 -: COLOR_BITS];
            b_s = grad_sum_s[7 -: COLOR_BITS];
        end else begin
            r_s = expand(pal_idx_s[2]);
            g_s = expand(pal_idx_s[1]);
            b_s = expand(pal_idx_s[0]);
        end
    end

endmodule
